rom_fetch_master: RTL and testbench

AXI4 read-only master that sits directly upstream of the ROM slave wrapper and serves instruction/boot fetches from the CPU side. It holds one 4-word line buffer; a hit returns data in one cycle, and a miss issues a 4-beat INCR burst, fills the line, then returns the requested word. The write channels are tied off because ROM is never written.

---
 rtl/rom_fetch_master.sv | 160 ++++++++++++++++
 tb/tb_rom_fetch_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rom_fetch_master - AXI4 read-only fetch master with a 4-word line buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module rom_fetch_master #(
   parameter int              ID_W     = 4,
   parameter logic [ID_W-1:0] ARID_VAL = '0
) (
   input  logic            ACLK,
   input  logic            ARESETn,
   input  logic            req_i,
   input  logic [31:0]     addr_i,
   input  logic            flush_i,
   output logic            done_o,
   output logic [31:0]     rdata_o,
   output logic            err_o,
   output logic [ID_W-1:0] ARID_M,
   output logic [31:0]     ARADDR_M,
   output logic [3:0]      ARLEN_M,
   output logic [2:0]      ARSIZE_M,
   output logic [1:0]      ARBURST_M,
   output logic            ARVALID_M,
   input  logic            ARREADY_M,
   input  logic [ID_W-1:0] RID_M,
   input  logic [31:0]     RDATA_M,
   input  logic [1:0]      RRESP_M,
   input  logic            RLAST_M,
   input  logic            RVALID_M,
   output logic            RREADY_M,
   output logic [ID_W-1:0] AWID_M,
   output logic [31:0]     AWADDR_M,
   output logic [3:0]      AWLEN_M,
   output logic [2:0]      AWSIZE_M,
   output logic [1:0]      AWBURST_M,
   output logic            AWVALID_M,
   output logic [31:0]     WDATA_M,
   output logic [3:0]      WSTRB_M,
   output logic            WLAST_M,
   output logic            WVALID_M,
   output logic            BREADY_M
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARQ  = 2'd1,
      RDAT = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t      state, state_nxt;
   logic [27:0] line_tag;
   logic        line_valid;
   logic [31:0] line_word [4];
   logic [31:2] fetch_addr;
   logic [1:0]  cnt;
   logic        burst_err;
   logic        flush_seen;
   logic        hit_done;
   logic        hit;
   logic        start_miss;
   logic        rbeat;
   logic        beat_err;
   logic        unused_inputs;

   assign unused_inputs = ^{RID_M, addr_i[1:0]};

   assign rbeat = (state == RDAT) && RVALID_M;
   // A last flag off beat 3, or a missing one on beat 3, is a malformed burst.
   assign beat_err = (RRESP_M != 2'b00) || (RLAST_M != (cnt == 2'd3));

   always_comb begin
      state_nxt  = state;
      hit        = 1'b0;
      start_miss = 1'b0;
      case (state)
         IDLE: begin
            // The request stays high during its own done cycle; ignore it then.
            if (req_i && !hit_done) begin
               if (line_valid && (line_tag == addr_i[31:4]) && !flush_i) begin
                  hit = 1'b1;
               end else begin
                  start_miss = 1'b1;
                  state_nxt  = ARQ;
               end
            end
         end
         ARQ:     if (ARREADY_M) state_nxt = RDAT;
         RDAT:    if (RVALID_M && RLAST_M) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         line_tag   <= '0;
         line_valid <= 1'b0;
         fetch_addr <= '0;
         cnt        <= 2'd0;
         burst_err  <= 1'b0;
         flush_seen <= 1'b0;
         hit_done   <= 1'b0;
      end else begin
         hit_done <= hit;
         if (hit || start_miss) fetch_addr <= addr_i[31:2];
         if (state == IDLE && flush_i) line_valid <= 1'b0;
         if (start_miss) begin
            line_valid <= 1'b0;
            burst_err  <= 1'b0;
            flush_seen <= 1'b0;
         end
         if (state != IDLE && flush_i) flush_seen <= 1'b1;
         if (state == ARQ && ARREADY_M) cnt <= 2'd0;
         if (rbeat) begin
            cnt <= cnt + 2'd1;
            if (beat_err) burst_err <= 1'b1;
         end
         if (state == DONE) begin
            line_tag   <= fetch_addr[31:4];
            line_valid <= !burst_err && !flush_seen && !flush_i;
         end
      end
   end

   always_ff @(posedge ACLK) begin
      if (rbeat) line_word[cnt] <= RDATA_M;
   end

   assign done_o  = (state == DONE) || hit_done;
   assign rdata_o = done_o ? line_word[fetch_addr[3:2]] : 32'h0;
   assign err_o   = (state == DONE) && burst_err;

   assign ARVALID_M = (state == ARQ);
   assign ARADDR_M  = {fetch_addr[31:4], 4'h0};
   assign ARLEN_M   = 4'd3;
   assign ARSIZE_M  = 3'b010;
   assign ARBURST_M = 2'b01;
   assign ARID_M    = ARID_VAL;
   assign RREADY_M  = (state == RDAT);

   assign AWID_M    = '0;
   assign AWADDR_M  = 32'h0;
   assign AWLEN_M   = 4'd0;
   assign AWSIZE_M  = 3'd0;
   assign AWBURST_M = 2'd0;
   assign AWVALID_M = 1'b0;
   assign WDATA_M   = 32'h0;
   assign WSTRB_M   = 4'h0;
   assign WLAST_M   = 1'b0;
   assign WVALID_M  = 1'b0;
   assign BREADY_M  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_master.sv
`default_nettype none
// Bench for rom_fetch_master: randomized fetches against a line-buffer model,
// an AXI ROM responder and a done_o scoreboard.
module tb_rom_fetch_master;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        req_i = 1'b0;
   logic [31:0] addr_i = 32'h0;
   logic        flush_i = 1'b0;
   logic        done_o, err_o;
   logic [31:0] rdata_o;
   logic [3:0]  ARID_M, RID_M, AWID_M;
   logic [31:0] ARADDR_M, RDATA_M, AWADDR_M, WDATA_M;
   logic [3:0]  ARLEN_M, AWLEN_M, WSTRB_M;
   logic [2:0]  ARSIZE_M, AWSIZE_M;
   logic [1:0]  ARBURST_M, RRESP_M, AWBURST_M;
   logic        ARVALID_M, ARREADY_M, RLAST_M, RVALID_M, RREADY_M;
   logic        AWVALID_M, WLAST_M, WVALID_M, BREADY_M;

   always #5 ACLK = ~ACLK;

   rom_fetch_master dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .req_i(req_i), .addr_i(addr_i),
      .flush_i(flush_i), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
      .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
      .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M),
      .ARREADY_M(ARREADY_M), .RID_M(RID_M), .RDATA_M(RDATA_M),
      .RRESP_M(RRESP_M), .RLAST_M(RLAST_M), .RVALID_M(RVALID_M),
      .RREADY_M(RREADY_M), .AWID_M(AWID_M), .AWADDR_M(AWADDR_M),
      .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M), .AWBURST_M(AWBURST_M),
      .AWVALID_M(AWVALID_M), .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M),
      .WLAST_M(WLAST_M), .WVALID_M(WVALID_M), .BREADY_M(BREADY_M)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rom(input logic [31:0] a);
      return {2'b00, a[31:2]} + 32'h10;
   endfunction

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t sb[$];

   // Responder configuration, set by the driver before each request
   int cfg_ar_delay = 0;
   int cfg_gap      = 0;
   int cfg_err_beat = -1;
   int cfg_nbeats   = 4;
   int ar_count     = 0;
   logic [31:0] cur_line = 32'h0;

   // Reference model of the line buffer
   logic        m_valid = 1'b0;
   logic [27:0] m_tag   = '0;

   // AXI ROM responder
   initial begin
      int phase, wait_cnt, beat;
      logic [31:0] base;
      logic ar_hs, r_hs;
      phase = 0; wait_cnt = 0; beat = 0; base = 32'h0;
      ARREADY_M = 1'b0; RVALID_M = 1'b0; RDATA_M = 32'h0;
      RRESP_M = 2'b00; RLAST_M = 1'b0; RID_M = '0;
      forever begin
         @(negedge ACLK);
         ar_hs = ARVALID_M && ARREADY_M;
         r_hs  = RVALID_M && RREADY_M;
         if (ar_hs) base = ARADDR_M;
         @(posedge ACLK);
         #1;
         if (!ARESETn) begin
            phase = 0; wait_cnt = 0; beat = 0;
            ARREADY_M = 1'b0; RVALID_M = 1'b0; RLAST_M = 1'b0;
            continue;
         end
         if (ar_hs) begin
            phase = 1; beat = 0; wait_cnt = 0; ARREADY_M = 1'b0;
         end
         if (r_hs) begin
            beat++;
            RVALID_M = 1'b0;
            RLAST_M  = 1'b0;
            if (beat >= cfg_nbeats) phase = 0;
         end
         if (phase == 0) begin
            if (ARVALID_M && !ARREADY_M) begin
               if (wait_cnt >= cfg_ar_delay) ARREADY_M = 1'b1;
               else wait_cnt++;
            end
         end else if (!RVALID_M) begin
            if (int'($urandom_range(0, 99)) >= cfg_gap) begin
               RVALID_M = 1'b1;
               RDATA_M  = rom(base + 32'(4 * beat));
               RRESP_M  = (beat == cfg_err_beat) ? 2'b10 : 2'b00;
               RLAST_M  = (beat == cfg_nbeats - 1);
            end
         end
      end
   end

   // Monitor: scoreboard pops on done_o, AR channel rules every cycle
   initial begin
      logic        pend;
      logic [63:0] prev_ar, cur_ar;
      exp_t        e;
      pend = 1'b0; prev_ar = '0;
      forever begin
         @(negedge ACLK);
         if (!ARESETn) begin
            pend = 1'b0;
            continue;
         end
         cur_ar = {19'h0, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARID_M};
         if (done_o) begin
            if (sb.size() == 0) begin
               check("spurious_done", 64'(done_o), 64'h0);
            end else begin
               e = sb.pop_front();
               check("rdata", 64'(rdata_o), 64'(e.data));
               check("err", 64'(err_o), 64'(e.err));
            end
         end
         if (ARVALID_M) begin
            check("ar_fields", cur_ar, {19'h0, cur_line, 4'd3, 3'd2, 2'd1, 4'd0});
            if (pend) check("ar_stable", cur_ar, prev_ar);
         end else if (pend) begin
            check("ar_dropped", 64'(ARVALID_M), 64'h1);
         end
         pend    = ARVALID_M && !ARREADY_M;
         prev_ar = cur_ar;
         if (ARVALID_M && ARREADY_M) ar_count++;
      end
   end

   task automatic fetch(input logic [31:0] addr, input bit fwr, input bit fmid,
                        input int err_beat, input int nbeats, input int ar_delay,
                        input int gap);
      bit miss, err, got;
      int ar0, lat;
      exp_t e;
      miss = fwr || !(m_valid && m_tag == addr[31:4]);
      err  = miss && ((err_beat >= 0 && err_beat < nbeats) || nbeats != 4);
      cfg_ar_delay = ar_delay; cfg_gap = gap;
      cfg_err_beat = err_beat; cfg_nbeats = nbeats;
      cur_line = {addr[31:4], 4'h0};
      e.data = rom(addr); e.err = err;
      sb.push_back(e);
      ar0 = ar_count;
      @(negedge ACLK);
      req_i = 1'b1; addr_i = addr; flush_i = fwr;
      got = 0; lat = 0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(posedge ACLK);
         #1;
         flush_i = fmid && (k == 1);
         if (done_o) begin got = 1; lat = k; end
      end
      if (!got) begin
         check("done_timeout", 64'h0, 64'h1);
         void'(sb.pop_front());
      end else if (ar_delay == 0 && gap == 0 && nbeats == 4) begin
         check("latency", 64'(lat), miss ? 64'd5 : 64'd0);
      end
      @(posedge ACLK);
      #1;
      req_i = 1'b0; flush_i = 1'b0;
      @(negedge ACLK);
      check("ar_count", 64'(ar_count - ar0), 64'(miss));
      if (miss) begin
         m_tag   = addr[31:4];
         m_valid = !err && !fmid;
      end
   endtask

   initial begin
      logic [31:0] a;
      int eb;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_arvalid", 64'(ARVALID_M), 64'h0);
      check("rst_rready", 64'(RREADY_M), 64'h0);
      check("rst_done", 64'(done_o), 64'h0);
      check("rst_err", 64'(err_o), 64'h0);
      check("rst_rdata", 64'(rdata_o), 64'h0);
      check("rst_araddr", 64'(ARADDR_M), 64'h0);
      check("tieoffs", 64'({AWVALID_M, WVALID_M, BREADY_M}), 64'b001);
      ARESETn = 1'b1;

      fetch(32'h0000_0008, 0, 0, -1, 4, 0, 0);   // cold miss
      fetch(32'h0000_000C, 0, 0, -1, 4, 0, 0);   // hit
      fetch(32'h0000_0010, 0, 0, -1, 4, 0, 0);   // replaces tag
      fetch(32'h0000_0004, 0, 0, -1, 4, 0, 0);   // misses again
      fetch(32'h0000_0024, 0, 0, -1, 4, 3, 50);  // slow AR, gapped R
      fetch(32'h0000_0028, 0, 0, -1, 4, 0, 0);
      fetch(32'h0000_0038, 0, 0, 2, 4, 0, 0);    // SLVERR on beat 2
      fetch(32'h0000_0030, 0, 0, -1, 4, 0, 0);   // must re-issue
      fetch(32'h0000_0044, 0, 0, -1, 3, 0, 0);   // early RLAST
      fetch(32'h0000_0040, 0, 0, -1, 4, 0, 0);
      fetch(32'h0000_0050, 0, 1, -1, 4, 0, 0);   // flush mid-burst
      fetch(32'h0000_0054, 0, 0, -1, 4, 0, 0);
      fetch(32'h0000_0058, 1, 0, -1, 4, 0, 0);   // flush with req -> miss

      // Reset in the middle of a burst
      cfg_ar_delay = 0; cfg_gap = 0; cfg_err_beat = -1; cfg_nbeats = 4;
      cur_line = 32'h0000_0060;
      @(negedge ACLK);
      req_i = 1'b1; addr_i = 32'h0000_0064;
      repeat (3) @(posedge ACLK);
      #2;
      ARESETn = 1'b0;
      req_i   = 1'b0;
      #1;
      check("midrst_arvalid", 64'(ARVALID_M), 64'h0);
      check("midrst_rready", 64'(RREADY_M), 64'h0);
      check("midrst_done", 64'(done_o), 64'h0);
      m_valid = 1'b0;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      ARESETn = 1'b1;
      fetch(32'h0000_0058, 0, 0, -1, 4, 0, 0);

      for (int i = 0; i < 60; i++) begin
         a = {($urandom_range(0, 1) == 1) ? 4'h8 : 4'h0, 22'h0,
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
         eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
         fetch(a, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, eb, 4,
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 60)));
      end

      repeat (3) @(negedge ACLK);
      check("sb_empty", 64'(sb.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
